bel_fft_seq: RTL and testbench

In-place radix-2 FFT pass sequencer for the bel_fft core. Walks all log2(N) stages over an N-point buffer, issuing one butterfly per cycle: read-pair addresses, twiddle index and the forward/inverse flag to the butterfly datapath, then matching write-back addresses once the datapath latency has elapsed. The datapath includes the complex add/sub element. Between stages it drains the datapath pipeline so no stage reads data the previous stage has not yet written.

---
 rtl/bel_fft_seq.sv | 145 ++++++++++++++
 tb/tb_bel_fft_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bel_fft_seq.sv
// In-place radix-2 FFT pass sequencer: issues one butterfly read per cycle per stage,
// delays the read pair by the datapath latency to form write-backs, drains between stages.
module bel_fft_seq #(
    parameter int addr_width = 10,
    parameter int dp_latency = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic                  inv_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [3:0]            stage_o,
    output logic                  rd_en_o,
    output logic [addr_width-1:0] rd_a_addr_o,
    output logic [addr_width-1:0] rd_b_addr_o,
    output logic [addr_width-2:0] tw_addr_o,
    output logic                  inv_o,
    output logic                  wr_en_o,
    output logic [addr_width-1:0] wr_a_addr_o,
    output logic [addr_width-1:0] wr_b_addr_o
);
    localparam int HW = addr_width - 1;
    localparam int DW = (dp_latency > 1) ? $clog2(dp_latency) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [3:0]      s, s_nxt;
    logic [HW-1:0]   k, k_nxt;
    logic [DW-1:0]   dcnt, dcnt_nxt;
    logic            inv_q, inv_nxt;
    logic            done_nxt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= IDLE;
            s      <= '0;
            k      <= '0;
            dcnt   <= '0;
            inv_q  <= 1'b0;
            done_o <= 1'b0;
        end else begin
            state  <= state_nxt;
            s      <= s_nxt;
            k      <= k_nxt;
            dcnt   <= dcnt_nxt;
            inv_q  <= inv_nxt;
            done_o <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        k_nxt     = k;
        dcnt_nxt  = dcnt;
        inv_nxt   = inv_q;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = RUN;
                    s_nxt     = '0;
                    k_nxt     = '0;
                    dcnt_nxt  = '0;
                    inv_nxt   = inv_i;
                end
            end
            RUN: begin
                if (k == '1) begin
                    state_nxt = DRAIN;
                    k_nxt     = '0;
                    dcnt_nxt  = '0;
                end else begin
                    k_nxt = k + HW'(1);
                end
            end
            DRAIN: begin
                if (dcnt == DW'(dp_latency - 1)) begin
                    dcnt_nxt = '0;
                    if (s == 4'(addr_width - 1)) begin
                        // s returns to 0 so stage_o reads 0 while idle
                        state_nxt = IDLE;
                        s_nxt     = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = RUN;
                        s_nxt     = s + 4'd1;
                    end
                end else begin
                    dcnt_nxt = dcnt + DW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Butterfly addressing: insert a zero bit at position s of k for the a-side.
    logic [HW-1:0]         mask, pos, grp, tw;
    logic [addr_width-1:0] rd_a, rd_b;

    always_comb begin
        mask = (HW'(1) << s) - HW'(1);
        pos  = k & mask;
        grp  = k >> s;
        rd_a = ({1'b0, grp} << (s + 4'd1)) | {1'b0, pos};
        rd_b = rd_a | (addr_width'(1) << s);
        tw   = pos << (HW - 32'(s));
    end

    assign busy_o      = (state != IDLE);
    assign rd_en_o     = (state == RUN);
    assign rd_a_addr_o = rd_en_o ? rd_a : '0;
    assign rd_b_addr_o = rd_en_o ? rd_b : '0;
    assign tw_addr_o   = rd_en_o ? tw : '0;
    assign stage_o     = s;
    assign inv_o       = inv_q;

    // Write-back delay line; keeps shifting in DRAIN/IDLE so each stage's tail lands in DRAIN.
    logic [dp_latency-1:0]                 vld_pipe;
    logic [dp_latency-1:0][addr_width-1:0] a_pipe, b_pipe;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_pipe <= '0;
            a_pipe   <= '0;
            b_pipe   <= '0;
        end else begin
            vld_pipe[0] <= rd_en_o;
            a_pipe[0]   <= rd_a_addr_o;
            b_pipe[0]   <= rd_b_addr_o;
            for (int i = 1; i < dp_latency; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                a_pipe[i]   <= a_pipe[i-1];
                b_pipe[i]   <= b_pipe[i-1];
            end
        end
    end

    assign wr_en_o     = vld_pipe[dp_latency-1];
    assign wr_a_addr_o = a_pipe[dp_latency-1];
    assign wr_b_addr_o = b_pipe[dp_latency-1];

endmodule

// File: tb/tb_bel_fft_seq.sv
// Bench for bel_fft_seq: small (N=8, latency 2) and default (N=1024, latency 4) instances,
// each checked every cycle against a cycle-indexed transform model plus directed checks.
module tb_bel_fft_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nbad = 0;

    task automatic chk(input string nm, input int act, input int want);
        nvec++;
        if (act != want) begin
            nbad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, want);
        end
    endtask

    // small instance
    logic       rst_s = 1'b0, start_s = 1'b0, inv_s = 1'b0;
    logic       busy_s, done_s, invo_s, rden_s, wren_s;
    logic [3:0] stage_s;
    logic [2:0] rda_s, rdb_s, wra_s, wrb_s;
    logic [1:0] tw_s;

    bel_fft_seq #(.addr_width(3), .dp_latency(2)) dut_s (
        .clk_i(clk), .rst_n_i(rst_s), .start_i(start_s), .inv_i(inv_s),
        .busy_o(busy_s), .done_o(done_s), .stage_o(stage_s), .rd_en_o(rden_s),
        .rd_a_addr_o(rda_s), .rd_b_addr_o(rdb_s), .tw_addr_o(tw_s), .inv_o(invo_s),
        .wr_en_o(wren_s), .wr_a_addr_o(wra_s), .wr_b_addr_o(wrb_s)
    );

    // default instance
    logic       rst_d = 1'b0, start_d = 1'b0, inv_d = 1'b0;
    logic       busy_d, done_d, invo_d, rden_d, wren_d;
    logic [3:0] stage_d;
    logic [9:0] rda_d, rdb_d, wra_d, wrb_d;
    logic [8:0] tw_d;

    bel_fft_seq dut_d (
        .clk_i(clk), .rst_n_i(rst_d), .start_i(start_d), .inv_i(inv_d),
        .busy_o(busy_d), .done_o(done_d), .stage_o(stage_d), .rd_en_o(rden_d),
        .rd_a_addr_o(rda_d), .rd_b_addr_o(rdb_d), .tw_addr_o(tw_d), .inv_o(invo_d),
        .wr_en_o(wren_d), .wr_a_addr_o(wra_d), .wr_b_addr_o(wrb_d)
    );

    // ---------------- model ----------------
    typedef struct {
        int busy, done, stage, rd_en, rd_a, rd_b, tw, wr_en, wr_a, wr_b;
    } exp_t;

    // Read issued in cycle c of a transform (cycle 1 = first read).
    function automatic void rd_at(input int aw, input int lat, input int c,
                                  output int en, output int a, output int b,
                                  output int tw, output int st);
        int half = 1 << (aw - 1);
        int per  = half + lat;
        int r, kk, pos, grp;
        en = 0; a = 0; b = 0; tw = 0; st = 0;
        if (c >= 1 && c <= aw * per) begin
            st = (c - 1) / per;
            r  = (c - 1) % per;
            if (r < half) begin
                kk  = r;
                pos = kk % (1 << st);
                grp = kk >> st;
                en  = 1;
                a   = grp * (2 << st) + pos;
                b   = a + (1 << st);
                tw  = pos << (aw - 1 - st);
            end
        end
    endfunction

    function automatic exp_t model(input int aw, input int lat, input int c);
        exp_t e;
        int   per = (1 << (aw - 1)) + lat;
        int   st, d0, d1;
        e.busy  = (c >= 1 && c <= aw * per) ? 1 : 0;
        e.done  = (c == aw * per + 1) ? 1 : 0;
        rd_at(aw, lat, c, e.rd_en, e.rd_a, e.rd_b, e.tw, st);
        e.stage = e.busy ? st : 0;
        rd_at(aw, lat, c - lat, e.wr_en, e.wr_a, e.wr_b, d0, d1);
        return e;
    endfunction

    // c = cycle index within the current transform, 0 = never started / reset
    int cs = 0, cd = 0;
    int invm_s = 0, invm_d = 0;
    localparam int TS = 3 * (4 + 2) + 1;
    localparam int TD = 10 * (512 + 4) + 1;

    always @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin cs = 0; invm_s = 0; end
        else if ((cs == 0 || cs >= TS) && start_s) begin cs = 1; invm_s = int'(inv_s); end
        else if (cs > 0) cs++;
    end

    always @(posedge clk or negedge rst_d) begin
        if (!rst_d) begin cd = 0; invm_d = 0; end
        else if ((cd == 0 || cd >= TD) && start_d) begin cd = 1; invm_d = int'(inv_d); end
        else if (cd > 0) cd++;
    end

    always @(negedge clk) begin
        exp_t e;
        e = model(3, 2, cs);
        chk("s.busy",  int'(busy_s),  e.busy);
        chk("s.done",  int'(done_s),  e.done);
        chk("s.stage", int'(stage_s), e.stage);
        chk("s.rd_en", int'(rden_s),  e.rd_en);
        chk("s.rd_a",  int'(rda_s),   e.rd_a);
        chk("s.rd_b",  int'(rdb_s),   e.rd_b);
        chk("s.tw",    int'(tw_s),    e.tw);
        chk("s.wr_en", int'(wren_s),  e.wr_en);
        chk("s.wr_a",  int'(wra_s),   e.wr_a);
        chk("s.wr_b",  int'(wrb_s),   e.wr_b);
        chk("s.inv",   int'(invo_s),  invm_s);
        e = model(10, 4, cd);
        chk("d.busy",  int'(busy_d),  e.busy);
        chk("d.done",  int'(done_d),  e.done);
        chk("d.stage", int'(stage_d), e.stage);
        chk("d.rd_en", int'(rden_d),  e.rd_en);
        chk("d.rd_a",  int'(rda_d),   e.rd_a);
        chk("d.rd_b",  int'(rdb_d),   e.rd_b);
        chk("d.tw",    int'(tw_d),    e.tw);
        chk("d.wr_en", int'(wren_d),  e.wr_en);
        chk("d.wr_a",  int'(wra_d),   e.wr_a);
        chk("d.wr_b",  int'(wrb_d),   e.wr_b);
        chk("d.inv",   int'(invo_d),  invm_d);
    end

    // ---------------- directed stimulus ----------------
    int lit_a[12]  = '{0,2,4,6, 0,1,4,5, 0,1,2,3};
    int lit_b[12]  = '{1,3,5,7, 2,3,6,7, 4,5,6,7};
    int lit_tw[12] = '{0,0,0,0, 0,2,0,2, 0,1,2,3};
    int qa[$], qb[$], qt[$], tw9[$];
    int rdcnt[10][1024];
    int wrcnt[10][1024];

    initial begin
        int cyc, busy_n, wr_n, bnd_bad, donecyc, n, badr, badw, twbad;
        logic prev_rd;

        repeat (3) @(negedge clk);
        chk("reset_busy_s", int'(busy_s), 0);
        chk("reset_rden_d", int'(rden_d), 0);
        rst_s = 1'b1; rst_d = 1'b1;
        repeat (3) @(negedge clk);

        // small transform, inverse
        start_s = 1'b1; inv_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0; inv_s = 1'b0;
        cyc = 1; busy_n = 0; wr_n = 0; bnd_bad = 0; donecyc = -1; prev_rd = 1'b0;
        while (cyc < 60 && donecyc < 0) begin
            if (busy_s) busy_n++;
            if (rden_s) begin qa.push_back(int'(rda_s)); qb.push_back(int'(rdb_s)); qt.push_back(int'(tw_s)); end
            if (wren_s) wr_n++;
            if (rden_s && !prev_rd && wren_s) bnd_bad++;
            prev_rd = rden_s;
            start_s = (cyc == 5);   // must be ignored while busy
            if (done_s) donecyc = cyc;
            else begin @(negedge clk); cyc++; end
        end
        chk("s_done_cycle", donecyc, 19);
        chk("s_busy_cycles", busy_n, 18);
        chk("s_write_count", wr_n, 12);
        chk("s_boundary_overlap", bnd_bad, 0);
        chk("s_read_count", qa.size(), 12);
        for (int i = 0; i < 12 && i < qa.size(); i++) begin
            chk($sformatf("s_lit_a[%0d]", i), qa[i], lit_a[i]);
            chk($sformatf("s_lit_b[%0d]", i), qb[i], lit_b[i]);
            chk($sformatf("s_lit_tw[%0d]", i), qt[i], lit_tw[i]);
        end

        // back-to-back start in the done cycle, forward
        start_s = 1'b1; inv_s = 1'b0;
        @(negedge clk);
        start_s = 1'b0;
        chk("s_b2b_rden", int'(rden_s), 1);
        chk("s_b2b_inv", int'(invo_s), 0);
        chk("s_b2b_rd_b", int'(rdb_s), 1);
        n = 0;
        while (!done_s && n < 40) begin @(negedge clk); n++; end
        chk("s_b2b_done_seen", int'(done_s), 1);
        repeat (2) @(negedge clk);

        // default instance: reset during stage 1
        start_d = 1'b1; inv_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        n = 0;
        while (stage_d != 4'd1 && n < 2000) begin @(negedge clk); n++; end
        chk("d_reach_stage1", int'(stage_d), 1);
        repeat (100) @(negedge clk);
        #2 rst_d = 1'b0;
        #1;
        chk("d_rst_busy", int'(busy_d), 0);
        chk("d_rst_rden", int'(rden_d), 0);
        chk("d_rst_wren", int'(wren_d), 0);
        chk("d_rst_stage", int'(stage_d), 0);
        chk("d_rst_inv", int'(invo_d), 0);
        chk("d_rst_rd_a", int'(rda_d), 0);
        chk("d_rst_wr_b", int'(wrb_d), 0);
        repeat (2) @(negedge clk);
        rst_d = 1'b1;
        repeat (3) @(negedge clk);

        // full default run with scoreboard
        start_d = 1'b1; inv_d = 1'b0;
        @(negedge clk);
        start_d = 1'b0;
        busy_n = 0; n = 0;
        while (!done_d && n < 6000) begin
            if (busy_d) busy_n++;
            if (rden_d && stage_d < 4'd10) begin
                rdcnt[stage_d][rda_d]++;
                rdcnt[stage_d][rdb_d]++;
                if (stage_d == 4'd9) tw9.push_back(int'(tw_d));
            end
            if (wren_d && stage_d < 4'd10) begin
                wrcnt[stage_d][wra_d]++;
                wrcnt[stage_d][wrb_d]++;
            end
            @(negedge clk); n++;
        end
        chk("d_done_seen", int'(done_d), 1);
        chk("d_busy_cycles", busy_n, 5160);
        badr = 0; badw = 0;
        for (int st = 0; st < 10; st++)
            for (int a = 0; a < 1024; a++) begin
                if (rdcnt[st][a] != 1) badr++;
                if (wrcnt[st][a] != 1) badw++;
            end
        chk("d_read_once", badr, 0);
        chk("d_write_once", badw, 0);
        chk("d_tw9_count", tw9.size(), 512);
        twbad = 0;
        foreach (tw9[i]) if (tw9[i] != i) twbad++;
        chk("d_tw9_order", twbad, 0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
